nes_cursor_painter: RTL and testbench

Paint engine between the NES controller interface and the RGB LED panel driver. It converts raw controller buttons into cursor moves, paint, erase, colour and clear actions on an on-chip 32x16 3-bit framebuffer. It serves that framebuffer to the panel driver one top/bottom row-pair pixel at a time, with a blinking cursor overlay.

---
 rtl/nes_cursor_painter.sv | 193 +++++++++++++++++++
 tb/tb_nes_cursor_painter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_cursor_painter.sv
// Paint engine: turns NES controller buttons into cursor/paint/colour/clear actions
// on a two-bank framebuffer, and serves pixel pairs to the panel driver with a blinking cursor.
module nes_cursor_painter #(
  parameter int COLS         = 32,
  parameter int ROWS         = 16,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int BLINK_HALF   = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              nes_btns,
  input  logic [$clog2(ROWS)-2:0] rd_row,
  input  logic [$clog2(COLS)-1:0] rd_col,
  output logic [2:0]              rd_rgb1,
  output logic [2:0]              rd_rgb2,
  output logic [$clog2(COLS)-1:0] cursor_x,
  output logic [$clog2(ROWS)-1:0] cursor_y,
  output logic [2:0]              color,
  output logic                    busy
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int AW    = CW + RW - 1;
  localparam int DEPTH = COLS * ROWS / 2;
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
  localparam int BLK_W = $clog2(BLINK_HALF + 1);

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t           state;
  logic [7:0]       btn;
  logic [7:0]       btn_prev;
  logic [7:0]       press;
  logic [AW-1:0]    clear_addr;
  logic [RPT_W-1:0] rpt_cnt;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink;
  logic             dir_held;
  logic             dir_press;
  logic             tick;
  logic             mv_up, mv_down, mv_left, mv_right;
  logic [CW-1:0]    next_x;
  logic [RW-1:0]    next_y;
  logic             moved;
  logic             we0, we1;
  logic [AW-1:0]    wr_addr;
  logic [2:0]       wr_data;
  logic [AW-1:0]    rd_addr;
  logic             hit1, hit2;

  logic [2:0] bank0 [DEPTH];
  logic [2:0] bank1 [DEPTH];

  assign press     = btn & ~btn_prev;
  assign dir_held  = |btn[BTN_RIGHT:BTN_UP];
  assign dir_press = |press[BTN_RIGHT:BTN_UP];
  assign tick      = dir_held && !dir_press && (rpt_cnt == RPT_W'(REPEAT_DELAY - 1));

  assign mv_up    = press[BTN_UP]    | (tick & btn[BTN_UP]);
  assign mv_down  = press[BTN_DOWN]  | (tick & btn[BTN_DOWN]);
  assign mv_left  = press[BTN_LEFT]  | (tick & btn[BTN_LEFT]);
  assign mv_right = press[BTN_RIGHT] | (tick & btn[BTN_RIGHT]);

  // Opposing requests on one axis cancel; power-of-two sizes give wrap for free.
  always_comb begin
    next_x = cursor_x;
    next_y = cursor_y;
    if (mv_up && !mv_down)       next_y = cursor_y - 1'b1;
    else if (mv_down && !mv_up)  next_y = cursor_y + 1'b1;
    if (mv_left && !mv_right)    next_x = cursor_x - 1'b1;
    else if (mv_right && !mv_left) next_x = cursor_x + 1'b1;
    moved = (next_x != cursor_x) || (next_y != cursor_y);
  end

  // Single write port: clear sweep owns both banks, otherwise erase beats paint.
  always_comb begin
    we0     = 1'b0;
    we1     = 1'b0;
    wr_addr = '0;
    wr_data = 3'b000;
    if (state == CLEAR) begin
      we0     = 1'b1;
      we1     = 1'b1;
      wr_addr = clear_addr;
    end else if (!press[BTN_START]) begin
      if (press[BTN_B]) begin
        wr_addr = {cursor_y[RW-2:0], cursor_x};
        we0     = !cursor_y[RW-1];
        we1     = cursor_y[RW-1];
      end else if (btn[BTN_A] && (press[BTN_A] || moved)) begin
        wr_addr = {next_y[RW-2:0], next_x};
        wr_data = color;
        we0     = !next_y[RW-1];
        we1     = next_y[RW-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= CLEAR;
      busy       <= 1'b1;
      clear_addr <= '0;
      cursor_x   <= '0;
      cursor_y   <= '0;
      color      <= 3'b100;
      btn        <= '0;
      btn_prev   <= '0;
    end else begin
      btn      <= ~nes_btns;
      btn_prev <= btn;
      case (state)
        CLEAR: begin
          clear_addr <= clear_addr + 1'b1;
          if (clear_addr == AW'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (press[BTN_START]) begin
            state      <= CLEAR;
            busy       <= 1'b1;
            clear_addr <= '0;
          end else begin
            cursor_x <= next_x;
            cursor_y <= next_y;
            if (press[BTN_SELECT])
              color <= (color == 3'd7) ? 3'd1 : color + 3'd1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // After a tick the counter is preloaded so the next tick lands REPEAT_RATE clocks later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt <= '0;
    end else if (!dir_held || dir_press) begin
      rpt_cnt <= '0;
    end else if (tick) begin
      rpt_cnt <= RPT_W'(REPEAT_DELAY - REPEAT_RATE);
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLK_W'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we0) bank0[wr_addr] <= wr_data;
    if (we1) bank1[wr_addr] <= wr_data;
  end

  assign rd_addr = {rd_row, rd_col};
  assign hit1 = blink && !cursor_y[RW-1] && (rd_row == cursor_y[RW-2:0]) && (rd_col == cursor_x);
  assign hit2 = blink &&  cursor_y[RW-1] && (rd_row == cursor_y[RW-2:0]) && (rd_col == cursor_x);

  // Registered read sees pre-write contents when addresses collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_rgb1 <= 3'b000;
      rd_rgb2 <= 3'b000;
    end else begin
      rd_rgb1 <= hit1 ? 3'b111 : bank0[rd_addr];
      rd_rgb2 <= hit2 ? 3'b111 : bank1[rd_addr];
    end
  end

endmodule

// File: tb/tb_nes_cursor_painter.sv
// Self-checking bench for nes_cursor_painter: vector table, hand-written corner sequences,
// and randomized buttons/reads checked every cycle against a pixel-level reference model.
module tb_nes_cursor_painter;

  localparam int COLS = 32;
  localparam int ROWS = 16;
  localparam int RD   = 10;
  localparam int RR   = 4;
  localparam int BH   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] nes_btns = 8'hFF;
  logic [2:0] rd_row = '0;
  logic [4:0] rd_col = '0;
  logic [2:0] rd_rgb1, rd_rgb2, color;
  logic [4:0] cursor_x;
  logic [3:0] cursor_y;
  logic       busy;

  always #5 clk = ~clk;

  nes_cursor_painter #(
    .COLS(COLS), .ROWS(ROWS), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .BLINK_HALF(BH)
  ) dut (
    .clk(clk), .reset(reset), .nes_btns(nes_btns), .rd_row(rd_row), .rd_col(rd_col),
    .rd_rgb1(rd_rgb1), .rd_rgb2(rd_rgb2), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .color(color), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 0;
  bit rd_rand = 0;

  // Reference model state: whole-picture view of the framebuffer plus cursor/colour.
  int       m_fb    [ROWS][COLS];
  bit       m_known [ROWS][COLS];
  int       m_cx, m_cy, m_color, m_clr_k, m_edge, m_press_cyc;
  bit       m_busy, m_rpt_valid;
  bit [7:0] m_btn, m_prev;
  int       m_rgb1, m_rgb2;
  bit       m_rgb1_known, m_rgb2_known;

  typedef struct {
    logic [7:0] btns;
    int         exp_x;
    int         exp_y;
    int         exp_color;
    string      name;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic modelReset();
    m_cx = 0; m_cy = 0; m_color = 4; m_busy = 1; m_clr_k = 0;
    m_btn = '0; m_prev = '0; m_edge = 0; m_rpt_valid = 0; m_press_cyc = 0;
    m_rgb1 = 0; m_rgb2 = 0; m_rgb1_known = 1; m_rgb2_known = 1;
  endtask

  task automatic modelStep();
    bit [7:0] pr;
    bit held, dpress, tick, bl;
    int d, dx, dy, nx, ny, r, c, kr, kc;
    pr = m_btn & ~m_prev;
    held = |m_btn[7:4];
    dpress = |pr[7:4];
    tick = 0;
    if (!held) m_rpt_valid = 0;
    else if (dpress) begin
      m_rpt_valid = 1;
      m_press_cyc = m_edge;
    end else if (m_rpt_valid) begin
      d = m_edge - m_press_cyc;
      tick = (d == RD) || (d > RD && ((d - RD) % RR) == 0);
    end
    bl = ((m_edge / BH) % 2) == 1;
    r = int'(rd_row);
    c = int'(rd_col);
    if (bl && m_cx == c && m_cy == r) begin
      m_rgb1 = 7; m_rgb1_known = 1;
    end else begin
      m_rgb1 = m_fb[r][c]; m_rgb1_known = m_known[r][c];
    end
    if (bl && m_cx == c && m_cy == r + ROWS/2) begin
      m_rgb2 = 7; m_rgb2_known = 1;
    end else begin
      m_rgb2 = m_fb[r + ROWS/2][c]; m_rgb2_known = m_known[r + ROWS/2][c];
    end
    if (m_busy) begin
      kr = m_clr_k / COLS;
      kc = m_clr_k % COLS;
      m_fb[kr][kc] = 0;          m_known[kr][kc] = 1;
      m_fb[kr + ROWS/2][kc] = 0; m_known[kr + ROWS/2][kc] = 1;
      m_clr_k++;
      if (m_clr_k == COLS * ROWS / 2) m_busy = 0;
    end else if (pr[3]) begin
      m_busy = 1;
      m_clr_k = 0;
    end else begin
      dx = int'(pr[7] | (tick & m_btn[7])) - int'(pr[6] | (tick & m_btn[6]));
      dy = int'(pr[5] | (tick & m_btn[5])) - int'(pr[4] | (tick & m_btn[4]));
      nx = (m_cx + dx + COLS) % COLS;
      ny = (m_cy + dy + ROWS) % ROWS;
      if (pr[1]) begin
        m_fb[m_cy][m_cx] = 0; m_known[m_cy][m_cx] = 1;
      end else if (m_btn[0] && (pr[0] || nx != m_cx || ny != m_cy)) begin
        m_fb[ny][nx] = m_color; m_known[ny][nx] = 1;
      end
      if (pr[2]) m_color = (m_color == 7) ? 1 : m_color + 1;
      m_cx = nx;
      m_cy = ny;
    end
    m_prev = m_btn;
    m_btn = ~nes_btns;
    m_edge++;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) modelReset();
    else modelStep();
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("cursor_x", int'(cursor_x), m_cx);
      checkOutput("cursor_y", int'(cursor_y), m_cy);
      checkOutput("color", int'(color), m_color);
      checkOutput("busy", int'(busy), int'(m_busy));
      if (m_rgb1_known) checkOutput("rd_rgb1", int'(rd_rgb1), m_rgb1);
      if (m_rgb2_known) checkOutput("rd_rgb2", int'(rd_rgb2), m_rgb2);
    end
  end

  always @(negedge clk) begin
    if (rd_rand) begin
      rd_row = 3'($urandom_range(0, 7));
      rd_col = 5'($urandom_range(0, 31));
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input int n);
    repeat (n) begin
      @(negedge clk);
      nes_btns = ~b;
    end
  endtask

  task automatic tap(input logic [7:0] b);
    applyStimulus(b, 1);
    applyStimulus(8'h00, 2);
  endtask

  task automatic readPixel(input int r, input int c, output int v1, output int v2);
    @(negedge clk);
    rd_rand = 0;
    rd_row = 3'(r);
    rd_col = 5'(c);
    @(negedge clk);
    v1 = int'(rd_rgb1);
    v2 = int'(rd_rgb2);
  endtask

  task automatic measureClear(input string name);
    int cyc;
    bit done;
    cyc = 0;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      cyc++;
      if (!busy) done = 1;
    end
    checkOutput({name, "_done"}, int'(done), 1);
    checkOutput({name, "_len"}, cyc, 256);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", int'(busy), 1);
    checkOutput("rst_x", int'(cursor_x), 0);
    checkOutput("rst_y", int'(cursor_y), 0);
    checkOutput("rst_color", int'(color), 4);
    checkOutput("rst_rgb1", int'(rd_rgb1), 0);
    checkOutput("rst_rgb2", int'(rd_rgb2), 0);
    #2 reset = 1'b1;
    measureClear("clear_after_reset");
  endtask

  task automatic setVec(input int i, input logic [7:0] b, input int x, input int y,
                        input int c, input string name);
    vecs[i].btns = b;
    vecs[i].exp_x = x;
    vecs[i].exp_y = y;
    vecs[i].exp_color = c;
    vecs[i].name = name;
  endtask

  initial begin
    int v1, v2, n7, n0, top0, hi;
    bit fin;
    logic [7:0] b;

    modelReset();
    setVec(0,  8'h40, 31, 0,  4, "left_wrap");
    setVec(1,  8'h10, 31, 15, 4, "up_wrap");
    setVec(2,  8'h80, 0,  15, 4, "right_wrap");
    setVec(3,  8'h20, 0,  0,  4, "down_wrap");
    setVec(4,  8'hC0, 0,  0,  4, "lr_cancel");
    setVec(5,  8'h30, 0,  0,  4, "ud_cancel");
    setVec(6,  8'hA0, 1,  1,  4, "diagonal");
    setVec(7,  8'h04, 1,  1,  5, "sel_5");
    setVec(8,  8'h04, 1,  1,  6, "sel_6");
    setVec(9,  8'h04, 1,  1,  7, "sel_7");
    setVec(10, 8'h04, 1,  1,  1, "sel_wrap");
    setVec(11, 8'h04, 1,  1,  2, "sel_2");

    repeat (3) @(negedge clk);
    check_en = 1;
    doReset();

    for (int r = 0; r < ROWS/2; r++)
      for (int c = 0; c < COLS; c++) begin
        @(negedge clk);
        rd_row = 3'(r);
        rd_col = 5'(c);
      end

    rd_rand = 1;
    foreach (vecs[i]) begin
      tap(vecs[i].btns);
      checkOutput({vecs[i].name, "_x"}, int'(cursor_x), vecs[i].exp_x);
      checkOutput({vecs[i].name, "_y"}, int'(cursor_y), vecs[i].exp_y);
      checkOutput({vecs[i].name, "_color"}, int'(color), vecs[i].exp_color);
    end

    repeat (4) tap(8'h80);
    repeat (8) tap(8'h20);
    checkOutput("goto_x", int'(cursor_x), 5);
    checkOutput("goto_y", int'(cursor_y), 9);

    tap(8'h01);
    tap(8'h40);
    readPixel(1, 5, v1, v2);
    checkOutput("paint_bottom", v2, 2);
    checkOutput("paint_top_untouched", v1, 0);

    tap(8'h80);
    tap(8'h03);
    tap(8'h40);
    readPixel(1, 5, v1, v2);
    checkOutput("a_b_erase", v2, 0);

    applyStimulus(8'h01, 2);
    applyStimulus(8'h81, 1);
    applyStimulus(8'h00, 2);
    tap(8'h40);
    readPixel(1, 5, v1, v2);
    checkOutput("a_held_move_paint", v2, 2);
    checkOutput("a_held_x", int'(cursor_x), 4);

    applyStimulus(8'h80, 30);
    applyStimulus(8'h00, 2);
    checkOutput("repeat_x", int'(cursor_x), 10);
    checkOutput("repeat_y", int'(cursor_y), 9);

    @(negedge clk);
    rd_row = 3'd1;
    rd_col = 5'd10;
    @(negedge clk);
    n7 = 0; n0 = 0; top0 = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (rd_rgb2 == 3'd7) n7++;
      else if (rd_rgb2 == 3'd0) n0++;
      if (rd_rgb1 == 3'd0) top0++;
    end
    checkOutput("blink_on_count", n7, 16);
    checkOutput("blink_off_count", n0, 16);
    checkOutput("blink_other_row", top0, 32);

    applyStimulus(8'h80, 3);
    applyStimulus(8'h88, 1);
    hi = 0;
    fin = 0;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge clk);
      if (i == 40) nes_btns = ~8'h40;
      if (i == 60) nes_btns = ~8'h05;
      if (i == 80) nes_btns = 8'hFF;
      if (busy) hi++;
      else if (hi > 0) fin = 1;
    end
    checkOutput("start_clear_done", int'(fin), 1);
    checkOutput("start_clear_len", hi, 256);
    checkOutput("clear_ignores_x", int'(cursor_x), 11);
    checkOutput("clear_ignores_y", int'(cursor_y), 9);
    checkOutput("clear_ignores_color", int'(color), 2);

    tap(8'h08);
    repeat (100) @(negedge clk);
    doReset();
    checkOutput("midclear_x", int'(cursor_x), 0);
    checkOutput("midclear_color", int'(color), 4);

    rd_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        b = 8'($urandom & $urandom);
        if ($urandom_range(0, 39) != 0) b[3] = 1'b0;
        nes_btns = ~b;
      end
    end
    nes_btns = 8'hFF;
    fin = 0;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge clk);
      if (!busy) fin = 1;
    end
    checkOutput("random_idle", int'(fin), 1);

    rd_rand = 0;
    for (int r = 0; r < ROWS/2; r++)
      for (int c = 0; c < COLS; c++) begin
        @(negedge clk);
        rd_row = 3'(r);
        rd_col = 5'(c);
      end
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #800_000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected test end");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
